// File: rtl/doorlock_pkg.sv
// Shared types and helpers for the keypad door lock: FSM state encoding and digit decoding.

package doorlock_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_PROG    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  localparam int unsigned DigitW = 4;

  // Index of the highest set bit; only meaningful when the input is one-hot.
  function automatic logic [DigitW-1:0] onehot_to_digit(input logic [9:0] oh);
    logic [DigitW-1:0] d;
    d = '0;
    for (int i = 0; i < 10; i++) begin
      if (oh[i]) d = DigitW'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/doorlock_ctrl_keypad_decode.sv
// Combinational decode of the ten digit keys into a single digit value plus validity flags.

module keypad_decode
  import doorlock_pkg::*;
(
  input  logic [9:0]        i_bt,
  output logic              o_digit_valid,
  output logic [DigitW-1:0] o_digit,
  output logic              o_multi_press
);

  logic w_any;
  logic w_onehot;

  assign w_any         = (i_bt != 10'd0);
  assign w_onehot      = w_any && ((i_bt & (i_bt - 10'd1)) == 10'd0);
  assign o_digit_valid = w_onehot;
  assign o_multi_press = w_any && !w_onehot;
  assign o_digit       = onehot_to_digit(i_bt);

endmodule

// File: rtl/doorlock_ctrl.sv
// Keypad door-lock sequencer: code entry and verify, timed unlock, failed-attempt lockout
// and in-place reprogramming of the stored code.

module doorlock_ctrl
  import doorlock_pkg::*;
#(
  parameter int unsigned            DIGITS         = 4,
  parameter logic [DIGITS*4-1:0]    DEFAULT_CODE   = 16'h1277,
  parameter int unsigned            MAX_FAIL       = 3,
  parameter int unsigned            UNLOCK_CYCLES  = 50,
  parameter int unsigned            LOCKOUT_CYCLES = 200,
  parameter int unsigned            TIMEOUT_CYCLES = 100
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic [9:0]                        bt,
  input  logic                              btstar,
  input  logic                              btsharp,
  output logic                              led,
  output logic                              locked_out,
  output logic                              prog_mode,
  output logic                              err,
  output logic                              ok,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

  localparam int unsigned CodeW  = DIGITS * DigitW;
  localparam int unsigned FailW  = $clog2(MAX_FAIL + 1);
  localparam int unsigned CntW   = $clog2(DIGITS + 1);
  localparam int unsigned MaxUL  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                    : LOCKOUT_CYCLES;
  localparam int unsigned MaxCyc = (MaxUL > TIMEOUT_CYCLES) ? MaxUL : TIMEOUT_CYCLES;
  localparam int unsigned TimerW = $clog2(MaxCyc + 1);

  // Loads are N-1 because the zero cycle itself counts toward the interval.
  localparam logic [TimerW-1:0] TimeoutLoad = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] UnlockLoad  = TimerW'(UNLOCK_CYCLES - 1);
  localparam logic [TimerW-1:0] LockoutLoad = TimerW'(LOCKOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] TimerOne    = TimerW'(1);
  localparam logic [CntW-1:0]   CntFull     = CntW'(DIGITS);
  localparam logic [CntW-1:0]   CntOne      = CntW'(1);
  localparam logic [FailW-1:0]  FailMax     = FailW'(MAX_FAIL);
  localparam logic [FailW-1:0]  FailOne     = FailW'(1);

  state_t             r_state, w_state_d;
  logic [CodeW-1:0]   r_buf, w_buf_d;
  logic [CntW-1:0]    r_cnt, w_cnt_d;
  logic               r_ovf, w_ovf_d;
  logic [TimerW-1:0]  r_timer, w_timer_d;
  logic [CodeW-1:0]   r_code, w_code_d;
  logic [FailW-1:0]   r_fail, w_fail_d;
  logic               r_led, r_locked, r_prog, r_err, r_ok;
  logic               w_err_d, w_ok_d;

  logic               w_digit_valid;
  logic [DigitW-1:0]  w_digit;
  logic               w_multi_press;
  logic               w_key_star, w_key_sharp, w_key_dig;
  logic               w_full_ok;
  logic [CodeW-1:0]   w_buf_shift;
  logic [FailW-1:0]   w_fail_inc;
  logic [TimerW-1:0]  w_timer_dec;

  keypad_decode u_keypad_decode (
    .i_bt          (bt),
    .o_digit_valid (w_digit_valid),
    .o_digit       (w_digit),
    .o_multi_press (w_multi_press)
  );

  assign w_key_star  = btstar;
  assign w_key_sharp = btsharp & ~btstar;
  assign w_key_dig   = w_digit_valid & ~w_multi_press & ~btstar & ~btsharp;

  assign w_full_ok   = (r_cnt == CntFull) && !r_ovf;
  assign w_buf_shift = {r_buf[CodeW-DigitW-1:0], w_digit};
  assign w_fail_inc  = (r_fail == FailMax) ? r_fail : r_fail + FailOne;
  assign w_timer_dec = (r_timer == '0) ? '0 : r_timer - TimerOne;

  always_comb begin
    w_state_d = r_state;
    w_buf_d   = r_buf;
    w_cnt_d   = r_cnt;
    w_ovf_d   = r_ovf;
    w_timer_d = r_timer;
    w_code_d  = r_code;
    w_fail_d  = r_fail;
    w_err_d   = 1'b0;
    w_ok_d    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_key_dig) begin
          w_buf_d   = {{(CodeW-DigitW){1'b0}}, w_digit};
          w_cnt_d   = CntOne;
          w_ovf_d   = 1'b0;
          w_timer_d = TimeoutLoad;
          w_state_d = S_ENTRY;
        end
      end

      S_ENTRY, S_PROG: begin
        if (w_key_star) begin
          w_buf_d   = '0;
          w_cnt_d   = '0;
          w_ovf_d   = 1'b0;
          w_timer_d = '0;
          w_state_d = S_IDLE;
          if (r_state == S_PROG) begin
            if (w_full_ok) begin
              w_code_d = r_buf;
              w_ok_d   = 1'b1;
            end else begin
              w_err_d  = 1'b1;
            end
          end else if (w_full_ok && (r_buf == r_code)) begin
            w_fail_d  = '0;
            w_timer_d = UnlockLoad;
            w_state_d = S_OPEN;
          end else begin
            w_err_d  = 1'b1;
            w_fail_d = w_fail_inc;
            if (w_fail_inc == FailMax) begin
              w_timer_d = LockoutLoad;
              w_state_d = S_LOCKOUT;
            end
          end
        end else if (w_key_dig) begin
          // A digit past the full length poisons the attempt but keeps the buffer.
          if (r_cnt < CntFull) begin
            w_buf_d = w_buf_shift;
            w_cnt_d = r_cnt + CntOne;
          end else begin
            w_ovf_d = 1'b1;
          end
          w_timer_d = TimeoutLoad;
        end else if (r_timer == '0) begin
          w_buf_d   = '0;
          w_cnt_d   = '0;
          w_ovf_d   = 1'b0;
          w_state_d = S_IDLE;
        end else begin
          w_timer_d = w_timer_dec;
        end
      end

      S_OPEN: begin
        if (w_key_star) begin
          w_timer_d = '0;
          w_state_d = S_IDLE;
        end else if (w_key_sharp) begin
          w_buf_d   = '0;
          w_cnt_d   = '0;
          w_ovf_d   = 1'b0;
          w_timer_d = TimeoutLoad;
          w_state_d = S_PROG;
        end else if (r_timer == '0) begin
          w_state_d = S_IDLE;
        end else begin
          w_timer_d = w_timer_dec;
        end
      end

      S_LOCKOUT: begin
        if (r_timer == '0) begin
          w_fail_d  = '0;
          w_state_d = S_IDLE;
        end else begin
          w_timer_d = w_timer_dec;
        end
      end

      default: begin
        w_buf_d   = '0;
        w_cnt_d   = '0;
        w_ovf_d   = 1'b0;
        w_timer_d = '0;
        w_state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= S_IDLE;
      r_buf    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_timer  <= '0;
      r_code   <= DEFAULT_CODE;
      r_fail   <= '0;
      r_led    <= 1'b0;
      r_locked <= 1'b0;
      r_prog   <= 1'b0;
      r_err    <= 1'b0;
      r_ok     <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_buf    <= w_buf_d;
      r_cnt    <= w_cnt_d;
      r_ovf    <= w_ovf_d;
      r_timer  <= w_timer_d;
      r_code   <= w_code_d;
      r_fail   <= w_fail_d;
      r_led    <= (w_state_d == S_OPEN);
      r_locked <= (w_state_d == S_LOCKOUT);
      r_prog   <= (w_state_d == S_PROG);
      r_err    <= w_err_d;
      r_ok     <= w_ok_d;
    end
  end

  assign led        = r_led;
  assign locked_out = r_locked;
  assign prog_mode  = r_prog;
  assign err        = r_err;
  assign ok         = r_ok;
  assign fail_cnt   = r_fail;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Self-checking bench for doorlock_ctrl: directed scenarios plus randomized key traffic,
// all compared each cycle against a behavioural model of the lock.

module tb_doorlock_ctrl;

  localparam int D   = 4;
  localparam int MXF = 3;
  localparam int UNL = 50;
  localparam int LCK = 200;
  localparam int TMO = 100;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_OPEN  = 2;
  localparam int M_PROG  = 3;
  localparam int M_LOCK  = 4;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [9:0] bt;
  logic       btstar, btsharp;
  logic       led, locked_out, prog_mode, err, ok;
  logic [1:0] fail_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model
  int m_mode;
  int m_buf[$];
  bit m_ovf;
  int m_idle;
  int m_left;
  int m_fails;
  int m_code[D];
  bit m_err, m_ok;

  always #5 clk = ~clk;

  doorlock_ctrl #(
    .DIGITS         (D),
    .DEFAULT_CODE   (16'h1277),
    .MAX_FAIL       (MXF),
    .UNLOCK_CYCLES  (UNL),
    .LOCKOUT_CYCLES (LCK),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bt         (bt),
    .btstar     (btstar),
    .btsharp    (btsharp),
    .led        (led),
    .locked_out (locked_out),
    .prog_mode  (prog_mode),
    .err        (err),
    .ok         (ok),
    .fail_cnt   (fail_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_buf.delete();
    m_ovf   = 0;
    m_idle  = 0;
    m_left  = 0;
    m_fails = 0;
    m_code  = '{1, 2, 7, 7};
    m_err   = 0;
    m_ok    = 0;
  endtask

  function automatic bit buf_is_code();
    if (m_buf.size() != D) return 0;
    for (int i = 0; i < D; i++) if (m_buf[i] != m_code[i]) return 0;
    return 1;
  endfunction

  task automatic collect(input int d);
    if (m_buf.size() < D) m_buf.push_back(d);
    else m_ovf = 1;
    m_idle = 0;
  endtask

  // One clock edge of the lock as the user would describe it.
  task automatic model_step(input logic [9:0] b, input logic s, input logic h);
    bit is_dig;
    int d;
    is_dig = (!s && !h && $countones(b) == 1);
    d = 0;
    for (int i = 0; i < 10; i++) if (b[i]) d = i;
    m_err = 0;
    m_ok  = 0;
    case (m_mode)
      M_IDLE: if (is_dig) begin
        m_buf.delete();
        m_buf.push_back(d);
        m_ovf  = 0;
        m_idle = 0;
        m_mode = M_ENTRY;
      end
      M_ENTRY, M_PROG: begin
        if (s) begin
          if (m_mode == M_PROG) begin
            if (m_buf.size() == D && !m_ovf) begin
              for (int i = 0; i < D; i++) m_code[i] = m_buf[i];
              m_ok = 1;
            end else m_err = 1;
            m_mode = M_IDLE;
          end else if (!m_ovf && buf_is_code()) begin
            m_fails = 0;
            m_left  = UNL;
            m_mode  = M_OPEN;
          end else begin
            m_err = 1;
            if (m_fails < MXF) m_fails++;
            if (m_fails == MXF) begin
              m_left = LCK;
              m_mode = M_LOCK;
            end else m_mode = M_IDLE;
          end
        end else if (is_dig) collect(d);
        else begin
          m_idle++;
          if (m_idle == TMO) m_mode = M_IDLE;
        end
      end
      M_OPEN: begin
        if (s) m_mode = M_IDLE;
        else if (h) begin
          m_buf.delete();
          m_ovf  = 0;
          m_idle = 0;
          m_mode = M_PROG;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
      M_LOCK: begin
        m_left--;
        if (m_left == 0) begin
          m_fails = 0;
          m_mode  = M_IDLE;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    check("led", 32'(led), 32'(m_mode == M_OPEN));
    check("locked_out", 32'(locked_out), 32'(m_mode == M_LOCK));
    check("prog_mode", 32'(prog_mode), 32'(m_mode == M_PROG));
    check("err", 32'(err), 32'(m_err));
    check("ok", 32'(ok), 32'(m_ok));
    check("fail_cnt", 32'(fail_cnt), 32'(m_fails));
  endtask

  task automatic step(input logic [9:0] b, input logic s, input logic h);
    @(negedge clk);
    bt      = b;
    btstar  = s;
    btsharp = h;
    @(posedge clk);
    model_step(b, s, h);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(10'd0, 1'b0, 1'b0);
  endtask

  task automatic key(input int d);
    step(10'(1 << d), 1'b0, 1'b0);
  endtask

  task automatic star();
    step(10'd0, 1'b1, 1'b0);
  endtask

  task automatic sharp();
    step(10'd0, 1'b0, 1'b1);
  endtask

  task automatic keys(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) key(int'(c[i*4 +: 4]));
  endtask

  task automatic enter_model_code();
    int c[D];
    c = m_code;
    for (int i = 0; i < D; i++) key(c[i]);
  endtask

  // Reset asserted between edges: outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    #1;
    n_rst = 1'b0;
    #1;
    model_reset();
    check({tag, "_led"}, 32'(led), 32'd0);
    check({tag, "_prog"}, 32'(prog_mode), 32'd0);
    check({tag, "_fail"}, 32'(fail_cnt), 32'd0);
    check({tag, "_lock"}, 32'(locked_out), 32'd0);
    @(negedge clk);
    bt = '0; btstar = 1'b0; btsharp = 1'b0;
    n_rst = 1'b1;
  endtask

  initial begin
    int n_led;
    n_rst = 1'b0;
    bt = '0; btstar = 1'b0; btsharp = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    // Correct code opens for exactly UNL cycles
    keys(16'h1277);
    star();
    n_led = int'(led);
    for (int i = 0; i < UNL + 10; i++) begin
      idle(1);
      n_led += int'(led);
    end
    check("unlock_len", 32'(n_led), 32'(UNL));

    // Three failures -> lockout, code ignored during lockout
    for (int i = 0; i < MXF; i++) begin
      keys(16'h0127);
      star();
    end
    check("lockout_on", 32'(locked_out), 32'd1);
    keys(16'h1277);
    star();
    idle(LCK);
    check("lockout_off", 32'(locked_out), 32'd0);
    keys(16'h1277);
    star();
    check("open_after_lock", 32'(led), 32'd1);
    idle(UNL);

    // Overflow digit, then entry timeout keeps fail count
    keys(16'h1277);
    key(3);
    star();
    key(1);
    key(2);
    idle(TMO + 2);
    check("timeout_fail_kept", 32'(fail_cnt), 32'd1);

    // Multi-press ignored; digit with star: only star acts
    key(1);
    step(10'h006, 1'b0, 1'b0);
    key(2);
    key(7);
    key(7);
    step(10'(1 << 3), 1'b1, 1'b0);
    check("multi_then_open", 32'(led), 32'd1);

    // Reprogram to 4560
    sharp();
    keys(16'h4560);
    star();
    check("prog_ok", 32'(ok), 32'd1);
    keys(16'h1277);
    star();
    keys(16'h4560);
    star();

    // Reset during unlock, then during programming
    async_reset("rst_open");
    keys(16'h1277);
    star();
    sharp();
    key(9);
    async_reset("rst_prog");
    keys(16'h1277);
    star();
    check("code_reverted", 32'(led), 32'd1);
    idle(UNL);

    // Randomized traffic
    for (int it = 0; it < 2500; it++) begin
      int r;
      int a;
      int c;
      r = $urandom_range(0, 99);
      a = $urandom_range(0, 9);
      c = (a + 1 + $urandom_range(0, 8)) % 10;
      if (r < 50) idle(1);
      else if (r < 75) key(a);
      else if (r < 81) star();
      else if (r < 86) sharp();
      else if (r < 90) step(10'(1 << a) | 10'(1 << c), 1'b0, 1'b0);
      else if (r < 93) step(10'(1 << a), 1'b1, 1'($urandom_range(0, 1)));
      else if (r < 98) begin
        enter_model_code();
        star();
        if ($urandom_range(0, 1) == 1) begin
          sharp();
          for (int i = 0; i < D; i++) key($urandom_range(0, 9));
          star();
        end
      end else idle(TMO);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
